clock_calendar_multialarm: RTL and testbench
============================================

# clock_calendar_multialarm

Parametrised successor to the lab 2 timekeeping top level. It keeps seconds, minutes and hours in 12- or 24-hour presentation, plus day-of-week, date and month with correct month lengths. It provides `NUM_ALARMS` independent alarm channels with per-channel enable, ring timeout and snooze. Outputs are binary values; the 7-segment and day-LED drivers sit outside the block and consume them.

## Interface
- `NUM_ALARMS`, 2: number of alarm channels, 1..8.
- `H24`, 0: 0 selects 12-hour presentation (hours 1..12 plus PM flag); 1 selects 24-hour presentation (hours 0..23).
- `SNOOZE_MIN`, 9: snooze delay in minutes, 1..59.
- `RING_SECS`, 60: ring duration before auto-stop, 1..255.
- `AW`, `$clog2(NUM_ALARMS)` (minimum 1): alarm-select width. Derived; never overridden.
- `Pulse` in 1: clock, one edge per second.
- `Reset` in 1: synchronous, active-high.
- `Timeset`, `Alarmset` in 1: set-mode buttons. When both are high, `Timeset` wins.
- `Minadv`, `Hrsadv`, `Dayadv`, `Dateadv`, `Monthadv` in 1: advance buttons, one step per cycle while high.
- `AlarmSel` in AW: alarm channel targeted by `Alarmset` and shown on the display.
- `AlarmOn` in NUM_ALARMS: per-channel arm bits.
- `Snooze` in 1: snooze button.
- `TSec` out 7: seconds 0..59.
- `TDay` out 3: day of week 0..6.
- `TDate` out 5: date 1..31.
- `TMonth` out 4: month 1..12.
- `DispMin`, `DispHrs` out 7: displayed minutes/hours (presentation-converted).
- `DispPm` out 1: PM flag for the displayed hours.
- `Ringing` out NUM_ALARMS: per-channel ring state.
- `Buzz` out 1: OR over channels of `Ringing & AlarmOn`.

## Operation
- **Internal time format.** Hours are stored 0..23 for both time and all alarms. Presentation is applied only at the outputs.
  - H24=0: displayed hour is h mod 12, with 0 shown as 12; PM = (h ≥ 12).
  - H24=1: displayed hour is h; PM = (h ≥ 12).
- **Display mux.** `DispMin`/`DispHrs`/`DispPm` show alarm[`AlarmSel`] while `Alarmset` is high and `Timeset` is low; otherwise they show current time. If `AlarmSel` ≥ NUM_ALARMS, the display shows alarm 0.
- **Natural counting** (`Timeset` low):
  - sec wraps 59→0 and carries to minutes.
  - min wraps 59→0 and carries to hours.
  - hour wraps 23→0 and carries to the calendar.
  - Calendar carry: day 6→0; date increments; at month length, date→1 and month increments; month 12→1.
  - Month lengths: 31,28,31,30,31,30,31,31,30,31,30,31. No leap years.
- **Timeset high:**
  - Seconds hold.
  - `Minadv` adds 1 to min mod 60. `Hrsadv` adds 1 to hour mod 24. `Dayadv` adds 1 to day mod 7. `Dateadv` advances date, wrapping at month length back to 1.
  - `Monthadv` advances month 12→1. If date exceeds the new month's length, date clamps to that length.
  - Manual advances never carry into other fields.
- **Alarmset high, Timeset low:**
  - Time runs normally.
  - `Minadv` and `Hrsadv` act on alarm[`AlarmSel`] only (mod 60 and mod 24 respectively).
  - `Dayadv`, `Dateadv` and `Monthadv` are ignored.
- **Per-channel alarm state machine** (channel i):
  - States: IDLE, RING, SNOOZED.
  - IDLE→RING when all hold: `AlarmOn[i]`, `Timeset` low, time min/hour equal alarm[i], and TSec == 0. The ring counter loads RING_SECS−1.
  - RING→IDLE when the ring counter reaches 0, or `AlarmOn[i]` is low.
  - RING→SNOOZED on `Snooze` high. The snooze counter loads SNOOZE_MIN·60−1 (12-bit).
  - SNOOZED→RING when the snooze counter reaches 0. The ring counter reloads.
  - SNOOZED→IDLE when `AlarmOn[i]` is low.
  - A match while in RING or SNOOZED is ignored.
  - `Snooze` affects only channels currently in RING.
- **`Reset` state.**
  - Time is 00:00:00 (displayed 12:00 AM when H24=0).
  - Day = 0, date = 1, month = 1.
  - All alarms are 00:00.
  - All channels are in IDLE with counters at 0, so `Ringing` = 0 and `Buzz` = 0.
  - `Reset` overrides every other input in the same cycle and aborts any ring or snooze in progress.

## Timing
- All state is registered on the `Pulse` rising edge. Outputs come from registers through combinational presentation logic only.
- **Carry chain:** the carry from sec 59 to 23:59:59 to the calendar occurs in the same edge as the sec wrap. There is no extra latency.
- **Ring latency:** the edge that makes TSec = 0 at a matching min/hour is cycle 0. `Ringing[i]` and `Buzz` rise at the end of cycle 1 and stay high for exactly RING_SECS cycles unless cancelled.
- **Snooze latency:** `Snooze` sampled high in cycle k drops `Ringing[i]` at k+1 and re-asserts it at k+1+SNOOZE_MIN·60.
- **`AlarmOn[i]` low:**
  - Masks `Buzz` combinationally in the same cycle.
  - Clears RING/SNOOZED at the next edge.
- **Simultaneous events:** if natural rollover and `Timeset` occur in the same cycle, `Timeset` rules apply and seconds hold. Several channels may ring at once, and `Buzz` is their OR.

## Test plan
- **Reset:** assert `Reset` for 1 cycle → TSec=0, `DispHrs`=12, `DispPm`=0, `TDate`=1, `TMonth`=1, `TDay`=0, `Buzz`=0. With H24=1, `DispHrs`=0.
- **Year-end rollover:** set month 12, date 31, time 23:59:50, day 6, then run 10 cycles → `TMonth`=1, `TDate`=1, `TDay`=0, time 00:00:00, `DispPm`=0. Also set Feb 28 23:59:59 and run 1 cycle → Mar 1.
- **Month clamp:** `Timeset` high with date 31 in month 1, pulse `Monthadv` once → month 2, date 28. Pulse `Dateadv` → date 1.
- **Alarm ring and timeout** (RING_SECS=60): alarm 1 = 07:00, `AlarmOn`=2'b10, run from 06:59:58 → `Buzz` high from the 3rd edge for 60 cycles, then low. Channel 0 stays IDLE.
- **Snooze and re-ring** (SNOOZE_MIN=9): press `Snooze` 5 cycles into a ring → `Buzz` low next cycle, high again 540 cycles later. Dropping `AlarmOn` during snooze keeps `Buzz` low permanently.
- **Priority, Reset mid-ring, and display mux:** with both `Timeset` and `Alarmset` high, `Hrsadv` changes time and leaves alarms untouched. `Reset` mid-ring drops `Buzz` on the next edge. With `Alarmset` high and `AlarmSel`=1, `DispMin`/`DispHrs` equal alarm 1.

Source files
------------

// File: rtl/clock_calendar_multialarm.sv
// Seconds/minutes/hours plus day/date/month keeper with NUM_ALARMS independent alarm channels.
// Everything advances on the Pulse edge; display outputs are the registers through presentation muxing only.
module clock_calendar_multialarm #(
   parameter int NUM_ALARMS = 2,
   parameter int H24        = 0,
   parameter int SNOOZE_MIN = 9,
   parameter int RING_SECS  = 60,
   parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  Pulse,
   input  logic                  Reset,
   input  logic                  Timeset,
   input  logic                  Alarmset,
   input  logic                  Minadv,
   input  logic                  Hrsadv,
   input  logic                  Dayadv,
   input  logic                  Dateadv,
   input  logic                  Monthadv,
   input  logic [AW-1:0]         AlarmSel,
   input  logic [NUM_ALARMS-1:0] AlarmOn,
   input  logic                  Snooze,
   output logic [6:0]            TSec,
   output logic [2:0]            TDay,
   output logic [4:0]            TDate,
   output logic [3:0]            TMonth,
   output logic [6:0]            DispMin,
   output logic [6:0]            DispHrs,
   output logic                  DispPm,
   output logic [NUM_ALARMS-1:0] Ringing,
   output logic                  Buzz
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RING    = 2'd1,
      SNOOZED = 2'd2
   } ch_state_t;

   localparam logic [7:0]  RING_LOAD  = 8'(RING_SECS - 1);
   localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * 60 - 1);

   logic [5:0] sec, min;
   logic [4:0] hour;
   logic [2:0] day;
   logic [4:0] date;
   logic [3:0] month;

   logic [5:0] sec_nx, min_nx;
   logic [4:0] hour_nx;
   logic [2:0] day_nx;
   logic [4:0] date_nx;
   logic [3:0] month_nx;

   logic [5:0]  alarm_min [NUM_ALARMS];
   logic [4:0]  alarm_hr  [NUM_ALARMS];
   ch_state_t   ch_state  [NUM_ALARMS];
   ch_state_t   ch_state_nx [NUM_ALARMS];
   logic [7:0]  ring_cnt  [NUM_ALARMS];
   logic [7:0]  ring_cnt_nx [NUM_ALARMS];
   logic [11:0] snz_cnt   [NUM_ALARMS];
   logic [11:0] snz_cnt_nx [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] match;

   logic          alarm_mode;
   logic [AW-1:0] sel_idx;
   logic [5:0]    shown_min;
   logic [4:0]    shown_hr;
   logic [4:0]    hr12;

   function automatic logic [4:0] month_len(input logic [3:0] m);
      case (m)
         4'd2:                     month_len = 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:  month_len = 5'd30;
         default:                  month_len = 5'd31;
      endcase
   endfunction

   assign alarm_mode = Alarmset & ~Timeset;
   // Out-of-range selects fall back to channel 0 for both display and editing.
   assign sel_idx    = (int'(AlarmSel) < NUM_ALARMS) ? AlarmSel : '0;

   // Time and calendar next state
   always_comb begin
      sec_nx   = sec;
      min_nx   = min;
      hour_nx  = hour;
      day_nx   = day;
      date_nx  = date;
      month_nx = month;
      if (Timeset) begin
         if (Minadv)  min_nx  = (min == 6'd59)  ? 6'd0 : min + 6'd1;
         if (Hrsadv)  hour_nx = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
         if (Dayadv)  day_nx  = (day == 3'd6)   ? 3'd0 : day + 3'd1;
         if (Dateadv) date_nx = (date >= month_len(month)) ? 5'd1 : date + 5'd1;
         if (Monthadv) begin
            month_nx = (month == 4'd12) ? 4'd1 : month + 4'd1;
            if (date_nx > month_len(month_nx)) date_nx = month_len(month_nx);
         end
      end else if (sec != 6'd59) begin
         sec_nx = sec + 6'd1;
      end else begin
         sec_nx = 6'd0;
         if (min != 6'd59) begin
            min_nx = min + 6'd1;
         end else begin
            min_nx = 6'd0;
            if (hour != 5'd23) begin
               hour_nx = hour + 5'd1;
            end else begin
               hour_nx = 5'd0;
               day_nx  = (day == 3'd6) ? 3'd0 : day + 3'd1;
               if (date >= month_len(month)) begin
                  date_nx  = 5'd1;
                  month_nx = (month == 4'd12) ? 4'd1 : month + 4'd1;
               end else begin
                  date_nx = date + 5'd1;
               end
            end
         end
      end
   end

   // Per-channel alarm FSM next state
   always_comb begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
         match[i]       = AlarmOn[i] & ~Timeset & (sec == 6'd0) &
                          (min == alarm_min[i]) & (hour == alarm_hr[i]);
         ch_state_nx[i] = ch_state[i];
         ring_cnt_nx[i] = ring_cnt[i];
         snz_cnt_nx[i]  = snz_cnt[i];
         case (ch_state[i])
            IDLE: begin
               if (match[i]) begin
                  ch_state_nx[i] = RING;
                  ring_cnt_nx[i] = RING_LOAD;
               end
            end
            RING: begin
               if (!AlarmOn[i] || ring_cnt[i] == 8'd0) begin
                  ch_state_nx[i] = IDLE;
                  ring_cnt_nx[i] = 8'd0;
               end else if (Snooze) begin
                  ch_state_nx[i] = SNOOZED;
                  ring_cnt_nx[i] = 8'd0;
                  snz_cnt_nx[i]  = SNOOZE_LOAD;
               end else begin
                  ring_cnt_nx[i] = ring_cnt[i] - 8'd1;
               end
            end
            SNOOZED: begin
               if (!AlarmOn[i]) begin
                  ch_state_nx[i] = IDLE;
                  snz_cnt_nx[i]  = 12'd0;
               end else if (snz_cnt[i] == 12'd0) begin
                  ch_state_nx[i] = RING;
                  ring_cnt_nx[i] = RING_LOAD;
               end else begin
                  snz_cnt_nx[i] = snz_cnt[i] - 12'd1;
               end
            end
            default: begin
               ch_state_nx[i] = IDLE;
               ring_cnt_nx[i] = 8'd0;
               snz_cnt_nx[i]  = 12'd0;
            end
         endcase
      end
   end

   always_ff @(posedge Pulse) begin
      if (Reset) begin
         sec   <= 6'd0;
         min   <= 6'd0;
         hour  <= 5'd0;
         day   <= 3'd0;
         date  <= 5'd1;
         month <= 4'd1;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_min[i] <= 6'd0;
            alarm_hr[i]  <= 5'd0;
            ch_state[i]  <= IDLE;
            ring_cnt[i]  <= 8'd0;
            snz_cnt[i]   <= 12'd0;
         end
      end else begin
         sec   <= sec_nx;
         min   <= min_nx;
         hour  <= hour_nx;
         day   <= day_nx;
         date  <= date_nx;
         month <= month_nx;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_mode && sel_idx == AW'(i)) begin
               if (Minadv) alarm_min[i] <= (alarm_min[i] == 6'd59) ? 6'd0 : alarm_min[i] + 6'd1;
               if (Hrsadv) alarm_hr[i]  <= (alarm_hr[i] == 5'd23)  ? 5'd0 : alarm_hr[i] + 5'd1;
            end
            ch_state[i] <= ch_state_nx[i];
            ring_cnt[i] <= ring_cnt_nx[i];
            snz_cnt[i]  <= snz_cnt_nx[i];
         end
      end
   end

   // Presentation
   assign shown_min = alarm_mode ? alarm_min[sel_idx] : min;
   assign shown_hr  = alarm_mode ? alarm_hr[sel_idx]  : hour;

   always_comb begin
      hr12 = shown_hr;
      if (shown_hr == 5'd0)       hr12 = 5'd12;
      else if (shown_hr > 5'd12)  hr12 = shown_hr - 5'd12;
   end

   assign TSec    = {1'b0, sec};
   assign TDay    = day;
   assign TDate   = date;
   assign TMonth  = month;
   assign DispMin = {1'b0, shown_min};
   assign DispHrs = (H24 != 0) ? {2'b00, shown_hr} : {2'b00, hr12};
   assign DispPm  = (shown_hr >= 5'd12);

   always_comb begin
      for (int i = 0; i < NUM_ALARMS; i++) Ringing[i] = (ch_state[i] == RING);
   end

   // AlarmOn masks the buzzer immediately, ahead of the FSM leaving RING.
   assign Buzz = |(Ringing & AlarmOn);

endmodule

// File: tb/tb_clock_calendar_multialarm.sv
// Randomized and directed bench: seconds-of-day reference model feeds a scoreboard queue,
// a monitor compares every Pulse cycle; a second instance checks 24-hour presentation.
module tb_clock_calendar_multialarm;
   localparam int NA  = 2;
   localparam int SNZ = 9;
   localparam int RS  = 60;

   logic Pulse = 1'b0, Reset = 1'b0, Timeset = 1'b0, Alarmset = 1'b0;
   logic Minadv = 1'b0, Hrsadv = 1'b0, Dayadv = 1'b0, Dateadv = 1'b0, Monthadv = 1'b0;
   logic [0:0] AlarmSel = 1'b0;
   logic [NA-1:0] AlarmOn = '0;
   logic Snooze = 1'b0;

   logic [6:0] TSec, DispMin, DispHrs;
   logic [2:0] TDay;
   logic [4:0] TDate;
   logic [3:0] TMonth;
   logic DispPm, Buzz;
   logic [NA-1:0] Ringing;

   logic [6:0] h_tsec, h_dmin, h_dhrs;
   logic [2:0] h_tday;
   logic [4:0] h_tdate;
   logic [3:0] h_tmonth;
   logic h_dpm, h_buzz;
   logic [NA-1:0] h_ring;

   clock_calendar_multialarm #(.NUM_ALARMS(NA), .H24(0), .SNOOZE_MIN(SNZ), .RING_SECS(RS)) dut (
      .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset), .Alarmset(Alarmset),
      .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv), .Dateadv(Dateadv), .Monthadv(Monthadv),
      .AlarmSel(AlarmSel), .AlarmOn(AlarmOn), .Snooze(Snooze),
      .TSec(TSec), .TDay(TDay), .TDate(TDate), .TMonth(TMonth),
      .DispMin(DispMin), .DispHrs(DispHrs), .DispPm(DispPm), .Ringing(Ringing), .Buzz(Buzz));

   clock_calendar_multialarm #(.NUM_ALARMS(NA), .H24(1), .SNOOZE_MIN(SNZ), .RING_SECS(RS)) dut24 (
      .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset), .Alarmset(Alarmset),
      .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv), .Dateadv(Dateadv), .Monthadv(Monthadv),
      .AlarmSel(AlarmSel), .AlarmOn(AlarmOn), .Snooze(Snooze),
      .TSec(h_tsec), .TDay(h_tday), .TDate(h_tdate), .TMonth(h_tmonth),
      .DispMin(h_dmin), .DispHrs(h_dhrs), .DispPm(h_dpm), .Ringing(h_ring), .Buzz(h_buzz));

   always #5 Pulse = ~Pulse;

   typedef struct {
      int tsec, dmin, dhrs, dpm, day, date, month, ring, buzz, dhrs24;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_err = 0;
   int buzz_cycles = 0;

   function automatic void check(input string name, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: time as seconds-of-day, alarms as minute-of-day.
   localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;
   int tod, mday, mdate, mmon;
   int am [NA];
   int st [NA];
   int rleft [NA];
   int sleft [NA];

   function automatic int mlen(input int m);
      case (m)
         2:           return 28;
         4, 6, 9, 11: return 30;
         default:     return 31;
      endcase
   endfunction

   task automatic model_step();
      int h, m, s, sel;
      bit hit [NA];
      sel = (int'(AlarmSel) < NA) ? int'(AlarmSel) : 0;
      if (Reset) begin
         tod = 0; mday = 0; mdate = 1; mmon = 1;
         for (int i = 0; i < NA; i++) begin
            am[i] = 0; st[i] = M_IDLE; rleft[i] = 0; sleft[i] = 0;
         end
      end else begin
         for (int i = 0; i < NA; i++)
            hit[i] = AlarmOn[i] && !Timeset && (tod % 60 == 0) && (tod / 60 == am[i]);
         for (int i = 0; i < NA; i++) begin
            if (st[i] == M_IDLE) begin
               if (hit[i]) begin st[i] = M_RING; rleft[i] = RS; end
            end else if (st[i] == M_RING) begin
               if (!AlarmOn[i] || rleft[i] == 1) st[i] = M_IDLE;
               else if (Snooze) begin st[i] = M_SNZ; sleft[i] = SNZ * 60; end
               else rleft[i]--;
            end else begin
               if (!AlarmOn[i]) st[i] = M_IDLE;
               else if (sleft[i] == 1) begin st[i] = M_RING; rleft[i] = RS; end
               else sleft[i]--;
            end
         end
         if (Timeset) begin
            h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
            if (Minadv) m = (m + 1) % 60;
            if (Hrsadv) h = (h + 1) % 24;
            if (Dayadv) mday = (mday + 1) % 7;
            if (Dateadv) mdate = (mdate >= mlen(mmon)) ? 1 : mdate + 1;
            if (Monthadv) begin
               mmon = mmon % 12 + 1;
               if (mdate > mlen(mmon)) mdate = mlen(mmon);
            end
            tod = h * 3600 + m * 60 + s;
         end else begin
            tod++;
            if (tod == 86400) begin
               tod = 0;
               mday = (mday + 1) % 7;
               if (mdate == mlen(mmon)) begin mdate = 1; mmon = mmon % 12 + 1; end
               else mdate++;
            end
            if (Alarmset) begin
               h = am[sel] / 60; m = am[sel] % 60;
               if (Minadv) m = (m + 1) % 60;
               if (Hrsadv) h = (h + 1) % 24;
               am[sel] = h * 60 + m;
            end
         end
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      int shown, hr, sel;
      sel = (int'(AlarmSel) < NA) ? int'(AlarmSel) : 0;
      shown = (Alarmset && !Timeset) ? am[sel] : tod / 60;
      hr = shown / 60;
      e.tsec   = tod % 60;
      e.dmin   = shown % 60;
      e.dhrs   = (hr % 12 == 0) ? 12 : hr % 12;
      e.dhrs24 = hr;
      e.dpm    = (hr >= 12) ? 1 : 0;
      e.day    = mday;
      e.date   = mdate;
      e.month  = mmon;
      e.ring   = 0;
      e.buzz   = 0;
      for (int i = 0; i < NA; i++) begin
         if (st[i] == M_RING) begin
            e.ring |= (1 << i);
            if (AlarmOn[i]) e.buzz = 1;
         end
      end
      return e;
   endfunction

   // Monitor: one expected entry per Pulse edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Pulse);
         #1;
         if (Buzz === 1'b1) buzz_cycles++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("TSec", TSec, e.tsec);
            check("DispMin", DispMin, e.dmin);
            check("DispHrs", DispHrs, e.dhrs);
            check("DispPm", DispPm, e.dpm);
            check("TDay", TDay, e.day);
            check("TDate", TDate, e.date);
            check("TMonth", TMonth, e.month);
            check("Ringing", Ringing, e.ring);
            check("Buzz", Buzz, e.buzz);
            check("DispHrs24", h_dhrs, e.dhrs24);
            check("DispPm24", h_dpm, e.dpm);
         end
      end
   end

   task automatic tick();
      model_step();
      sb.push_back(model_out());
      @(negedge Pulse);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   // btn: 0 min, 1 hrs, 2 day, 3 date, 4 month
   task automatic press(input int btn, input int n);
      for (int k = 0; k < n; k++) begin
         Minadv = (btn == 0); Hrsadv = (btn == 1); Dayadv = (btn == 2);
         Dateadv = (btn == 3); Monthadv = (btn == 4);
         tick();
      end
      {Minadv, Hrsadv, Dayadv, Dateadv, Monthadv} = 5'b0;
   endtask

   // Alarm 1 = 07:00, time 06:59:58, channel 1 armed, then three edges into the ring.
   task automatic setup_ring();
      AlarmOn = '0;
      do_reset();
      Alarmset = 1'b1; AlarmSel = 1'b1;
      press(1, 7);
      check("alarm1_hrs", DispHrs, 7);
      check("alarm1_min", DispMin, 0);
      Alarmset = 1'b0;
      run(51);
      Timeset = 1'b1;
      press(1, 6);
      press(0, 59);
      Timeset = 1'b0;
      AlarmOn = 2'b10;
      run(2);
      check("buzz_before_ring", Buzz, 0);
      tick();
      check("buzz_ring_start", Buzz, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      int b0, r;
      @(negedge Pulse);
      do_reset();
      check("rst_TSec", TSec, 0);
      check("rst_DispHrs", DispHrs, 12);
      check("rst_DispPm", DispPm, 0);
      check("rst_TDate", TDate, 1);
      check("rst_TMonth", TMonth, 1);
      check("rst_TDay", TDay, 0);
      check("rst_Buzz", Buzz, 0);
      check("rst_DispHrs24", h_dhrs, 0);

      // Year-end rollover
      run(50);
      Timeset = 1'b1;
      press(4, 11); press(3, 30); press(1, 23); press(0, 59); press(2, 6);
      Timeset = 1'b0;
      run(10);
      check("ye_month", TMonth, 1);
      check("ye_date", TDate, 1);
      check("ye_day", TDay, 0);
      check("ye_sec", TSec, 0);
      check("ye_min", DispMin, 0);
      check("ye_hrs", DispHrs, 12);
      check("ye_pm", DispPm, 0);

      // Feb 28 -> Mar 1
      do_reset();
      run(59);
      Timeset = 1'b1;
      press(4, 1); press(3, 27); press(1, 23); press(0, 59);
      Timeset = 1'b0;
      tick();
      check("feb_month", TMonth, 3);
      check("feb_date", TDate, 1);

      // Month clamp and date wrap
      do_reset();
      Timeset = 1'b1;
      press(3, 30);
      press(4, 1);
      check("clamp_month", TMonth, 2);
      check("clamp_date", TDate, 28);
      press(3, 1);
      check("clamp_wrap", TDate, 1);
      Timeset = 1'b0;

      // Ring and timeout
      setup_ring();
      b0 = buzz_cycles;
      run(70);
      check("ring_len", buzz_cycles - b0 + 1, RS);
      check("ring_ch0", Ringing[0], 0);

      // Snooze, re-ring, then cancel during snooze
      setup_ring();
      run(4);
      Snooze = 1'b1; tick(); Snooze = 1'b0;
      check("snooze_drop", Buzz, 0);
      b0 = buzz_cycles;
      run(SNZ * 60 - 1);
      check("snooze_quiet", buzz_cycles - b0, 0);
      tick();
      check("snooze_rering", Buzz, 1);
      Snooze = 1'b1; tick(); Snooze = 1'b0;
      AlarmOn = 2'b00; tick();
      AlarmOn = 2'b10;
      b0 = buzz_cycles;
      run(600);
      check("snooze_cancel", buzz_cycles - b0, 0);

      // Reset mid-ring
      setup_ring();
      run(2);
      Reset = 1'b1; tick(); Reset = 1'b0;
      check("rst_midring", Buzz, 0);

      // Timeset beats Alarmset; then display mux shows alarm 1
      AlarmOn = '0;
      do_reset();
      Timeset = 1'b1; Alarmset = 1'b1; AlarmSel = 1'b1;
      press(1, 1);
      check("prio_time_hrs", DispHrs, 1);
      Timeset = 1'b0;
      #1;
      check("prio_alarm_hrs", DispHrs, 12);
      Alarmset = 1'b0;

      // Randomized phase: alarms near the current time so rings occur
      do_reset();
      Alarmset = 1'b1;
      AlarmSel = 1'b0; press(0, 2);
      AlarmSel = 1'b1; press(0, 3);
      Alarmset = 1'b0;
      AlarmOn = 2'b11;
      for (int k = 0; k < 3000; k++) begin
         Reset    = ($urandom_range(0, 499) == 0);
         Timeset  = ($urandom_range(0, 29) == 0);
         Alarmset = ($urandom_range(0, 19) == 0);
         AlarmSel = 1'($urandom_range(0, 1));
         Snooze   = ($urandom_range(0, 24) == 0);
         r = $urandom_range(0, 19);
         Minadv = (r == 0); Hrsadv = (r == 1); Dayadv = (r == 2);
         Dateadv = (r == 3); Monthadv = (r == 4);
         if ($urandom_range(0, 59) == 0) AlarmOn = 2'($urandom_range(0, 3));
         tick();
      end
      {Reset, Timeset, Alarmset, Snooze, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv} = '0;
      run(3);
      @(negedge Pulse);
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
